channel_frame_dispatch: RTL and testbench

- Fork side of the per-frame channel handshake: broadcasts one start pulse per frame to each of the NUM_CHANNELS parallel bandpower engines.
- Each engine receives its start only when it signals ready, so busy engines are launched later rather than skipped.
- Emits dispatch_done once every enabled channel has been launched, and tags the frame with a sequence id.
- Sits between the sample-window framer and the per-channel engines; the completion-side barrier collects the engines' done pulses.

---
 rtl/ecg_frame_pkg.sv | 13 +
 rtl/sat_counter.sv | 36 +++
 rtl/channel_frame_dispatch.sv | 173 +++++++++++++++++
 tb/tb_channel_frame_dispatch.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ecg_frame_pkg.sv
// Shared definitions for the per-frame channel fork/join handshake (dispatch and completion barrier).
package ecg_frame_pkg;

  localparam int unsigned NUM_CHANNELS_DEF   = 8;
  localparam int unsigned FRAME_ID_W_DEF     = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at SAT_MAX; synchronous active-high reset.
module sat_counter #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] SAT_MAX = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next count: hold at the saturation value
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != SAT_MAX)) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/channel_frame_dispatch.sv
// Per-frame fork: launches each enabled channel engine once it is ready, then signals dispatch_done.
// Optional watchdog abort is built when FRAME_DISPATCH_TIMEOUT_EN is defined.
module channel_frame_dispatch
  import ecg_frame_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = NUM_CHANNELS_DEF,
  parameter int unsigned FRAME_ID_W     = FRAME_ID_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [NUM_CHANNELS-1:0] chan_en,
  input  logic [NUM_CHANNELS-1:0] chan_ready,
  output logic [NUM_CHANNELS-1:0] chan_start,
  output logic                    dispatch_done,
  output logic                    busy,
  output logic [FRAME_ID_W-1:0]   frame_id,
  output logic                    overrun,
  output logic [7:0]              overrun_cnt,
  output logic                    dispatch_timeout,
  output logic [NUM_CHANNELS-1:0] timeout_mask
);

  state_e                  state_q, state_d;
  logic [NUM_CHANNELS-1:0] pending_q, pending_d;
  logic [NUM_CHANNELS-1:0] chan_start_q, chan_start_d;
  logic [FRAME_ID_W-1:0]   next_id_q, next_id_d;
  logic [FRAME_ID_W-1:0]   frame_id_q, frame_id_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;
  logic [NUM_CHANNELS-1:0] launch_s;
  logic [NUM_CHANNELS-1:0] remain_s;
  logic                    drop_s;
  logic                    timeout_hit_s;

  // While dispatching, only pending channels are looked at.
  assign launch_s = pending_q & chan_ready;
  assign remain_s = pending_q & ~chan_ready;
  assign drop_s   = frame_start && (state_q == ST_DISPATCH);

  // next-state and launch decisions
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    next_id_d    = next_id_q;
    frame_id_d   = frame_id_q;
    chan_start_d = '0;
    done_d       = 1'b0;
    overrun_d    = drop_s;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          frame_id_d   = next_id_q;
          next_id_d    = next_id_q + {{(FRAME_ID_W-1){1'b0}}, 1'b1};
          chan_start_d = chan_en & chan_ready;
          pending_d    = chan_en & ~chan_ready;
          if ((chan_en & ~chan_ready) == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_DISPATCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        chan_start_d = launch_s;
        pending_d    = remain_s;
        if (remain_s == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout_hit_s) begin
          pending_d = '0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_DISPATCH;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
      end
    endcase
  end

  // dispatch state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      next_id_q    <= '0;
      frame_id_q   <= '0;
      chan_start_q <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      next_id_q    <= next_id_d;
      frame_id_q   <= frame_id_d;
      chan_start_q <= chan_start_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  sat_counter #(
    .WIDTH   (8),
    .SAT_MAX (8'd255)
  ) u_overrun_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_s),
    .count (overrun_cnt)
  );

`ifdef FRAME_DISPATCH_TIMEOUT_EN
  localparam int unsigned      WD_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    tmo_q, tmo_d;
  logic [NUM_CHANNELS-1:0] tmask_q, tmask_d;

  // Only a frame that still has channels left after this cycle's launch can time out.
  assign timeout_hit_s = (state_q == ST_DISPATCH) && (wd_q == WD_MAX) && (remain_s != '0);

  // watchdog next values
  always_comb begin
    wd_d    = wd_q;
    tmo_d   = timeout_hit_s;
    tmask_d = tmask_q;
    if (state_q == ST_IDLE) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
    end
    if (timeout_hit_s) begin
      tmask_d = remain_s;
    end else begin
      tmask_d = tmask_q;
    end
  end

  // watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      tmo_q   <= 1'b0;
      tmask_q <= '0;
    end else begin
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
      tmask_q <= tmask_d;
    end
  end

  assign dispatch_timeout = tmo_q;
  assign timeout_mask     = tmask_q;
`else
  assign timeout_hit_s    = 1'b0;
  assign dispatch_timeout = (TIMEOUT_CYCLES < 32'd2) ? 1'b0 : 1'b0;
  assign timeout_mask     = '0;
`endif

  assign chan_start    = chan_start_q;
  assign dispatch_done = done_q;
  assign busy          = (state_q == ST_DISPATCH);
  assign frame_id      = frame_id_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_channel_frame_dispatch.sv
// Table-driven, scoreboard-checked bench for channel_frame_dispatch (8 channels, 8-bit frame id).
module tb_channel_frame_dispatch;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic [7:0] chan_en;
  logic [7:0] chan_ready;
  logic [7:0] chan_start;
  logic       dispatch_done;
  logic       busy;
  logic [7:0] frame_id;
  logic       overrun;
  logic [7:0] overrun_cnt;
  logic       dispatch_timeout;
  logic [7:0] timeout_mask;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst;
    logic       fs;
    logic [7:0] en;
    logic [7:0] rdy;
    logic [7:0] cs;
    logic       done;
    logic       busy;
    logic       ovr;
    logic [7:0] fid;
    logic [7:0] cnt;
    logic       tmo;
    logic [7:0] tmask;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[16];

  channel_frame_dispatch #(
    .NUM_CHANNELS   (8),
    .FRAME_ID_W     (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .frame_start      (frame_start),
    .chan_en          (chan_en),
    .chan_ready       (chan_ready),
    .chan_start       (chan_start),
    .dispatch_done    (dispatch_done),
    .busy             (busy),
    .frame_id         (frame_id),
    .overrun          (overrun),
    .overrun_cnt      (overrun_cnt),
    .dispatch_timeout (dispatch_timeout),
    .timeout_mask     (timeout_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic fs, logic [7:0] en, logic [7:0] rdy,
                              logic [7:0] cs, logic done, logic bsy, logic ovr,
                              logic [7:0] fid, logic [7:0] cnt, logic tmo, logic [7:0] tmask);
    vec_t v;
    v.rst = r; v.fs = fs; v.en = en; v.rdy = rdy;
    v.cs = cs; v.done = done; v.busy = bsy; v.ovr = ovr;
    v.fid = fid; v.cnt = cnt; v.tmo = tmo; v.tmask = tmask;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, req);
    end
  endtask

  // Pop the expectation pushed when the stimulus was driven and compare all outputs.
  task automatic check_out(int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty step=%0d actual=0 required=1", idx);
    end else begin
      e = exp_q.pop_front();
      chk("chan_start", idx, chan_start, e.cs);
      chk("dispatch_done", idx, {7'd0, dispatch_done}, {7'd0, e.done});
      chk("busy", idx, {7'd0, busy}, {7'd0, e.busy});
      chk("overrun", idx, {7'd0, overrun}, {7'd0, e.ovr});
      chk("frame_id", idx, frame_id, e.fid);
      chk("overrun_cnt", idx, overrun_cnt, e.cnt);
      chk("dispatch_timeout", idx, {7'd0, dispatch_timeout}, {7'd0, e.tmo});
      chk("timeout_mask", idx, timeout_mask, e.tmask);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    rst         = v.rst;
    frame_start = v.fs;
    chan_en     = v.en;
    chan_ready  = v.rdy;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_out(idx);
  endtask

  initial begin
    int  cnt_m;
    logic [7:0] tm;
    rst = 1'b1; frame_start = 1'b0; chan_en = 8'h00; chan_ready = 8'h00;
    tm = 8'h00;

    //           rst   fs    en     rdy    cs     done  busy  ovr   fid    cnt    tmo   tmask
    tbl[0]  = mk(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'h00);
    tbl[1]  = mk(1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'h00);
    tbl[2]  = mk(1'b0, 1'b1, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0, 8'h00);
    tbl[3]  = mk(1'b0, 1'b0, 8'hFF, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0, 8'h00);
    tbl[4]  = mk(1'b0, 1'b0, 8'hFF, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0, 8'h00);
    tbl[5]  = mk(1'b0, 1'b0, 8'hFF, 8'h3F, 8'h30, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0, 8'h00);
    tbl[6]  = mk(1'b0, 1'b0, 8'hFF, 8'h3F, 8'h00, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0, 8'h00);
    tbl[7]  = mk(1'b0, 1'b0, 8'hFF, 8'hFF, 8'hC0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0, 8'h00);
    tbl[8]  = mk(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 1'b0, 8'h00);
    tbl[9]  = mk(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 8'h00);
    tbl[10] = mk(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'd3, 8'd1, 1'b0, 8'h00);
    tbl[11] = mk(1'b0, 1'b0, 8'h00, 8'h81, 8'h81, 1'b0, 1'b1, 1'b0, 8'd3, 8'd1, 1'b0, 8'h00);
    tbl[12] = mk(1'b0, 1'b1, 8'h00, 8'hFF, 8'h7E, 1'b1, 1'b0, 1'b1, 8'd3, 8'd2, 1'b0, 8'h00);
    tbl[13] = mk(1'b0, 1'b1, 8'h81, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'd4, 8'd2, 1'b0, 8'h00);
    tbl[14] = mk(1'b0, 1'b0, 8'hFF, 8'hFF, 8'h81, 1'b1, 1'b0, 1'b0, 8'd4, 8'd2, 1'b0, 8'h00);
    tbl[15] = mk(1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'd4, 8'd2, 1'b0, 8'h00);

    // reset state
    apply(mk(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'h00), 1000);
    apply(mk(1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'h00), 1001);

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i], i);
    end

    // overrun saturation: hold a frame pending and hammer frame_start
    apply(mk(1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'd5, 8'd2, 1'b0, 8'h00), 2000);
    cnt_m = 2;
    for (int i = 0; i < 300; i++) begin
      cnt_m = (cnt_m < 255) ? cnt_m + 1 : 255;
      apply(mk(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'd5, 8'(cnt_m), 1'b0, 8'h00),
            2001 + i);
    end
    apply(mk(1'b0, 1'b0, 8'h00, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 8'd5, 8'd255, 1'b0, 8'h00), 2400);

    // reset mid-dispatch with pending F0
    apply(mk(1'b0, 1'b1, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1'b1, 1'b0, 8'd6, 8'd255, 1'b0, 8'h00), 3000);
    apply(mk(1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'h00), 3001);
    apply(mk(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'h00), 3002);
    apply(mk(1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'h00), 3003);

    // frame id wraps 255 -> 0
    for (int i = 1; i < 257; i++) begin
      apply(mk(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'(i % 256), 8'd0, 1'b0, 8'h00),
            4000 + i);
    end

`ifdef FRAME_DISPATCH_TIMEOUT_EN
    // watchdog abort after 16 dispatch cycles with channel 7 never ready
    apply(mk(1'b0, 1'b1, 8'hFF, 8'h7F, 8'h7F, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0, 8'h00), 5000);
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) tm = 8'h80;
      apply(mk(1'b0, 1'b0, 8'hFF, 8'h7F, 8'h00, 1'b0, (k < 16), 1'b0, 8'd1, 8'd0,
               (k == 16), tm), 5000 + k);
    end
    apply(mk(1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0, 8'h80), 5100);
    apply(mk(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 1'b0, 8'h80), 5101);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
